// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared PC-source select codes and PC controller state encoding.
package msrv32_pkg;
    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_TRAP,
        ST_MRET,
        ST_WFI
    } pc_ctrl_state_t;
endpackage

// File: rtl/msrv32_pc_ctrl_if.sv
// msrv32_pc_ctrl_if: fetch-stage signals between the PC controller (slave) and its environment (master).
interface msrv32_pc_ctrl_if;
    logic        ahb_ready_in;
    logic [31:0] pc_mux_in;
    logic        misaligned_instr_in;
    logic        trap_taken_in;
    logic        mret_in;
    logic        wfi_in;
    logic        irq_pending_in;
    logic [1:0]  pc_src_out;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        stall_out;
    logic        misaligned_trap_out;
    logic        bus_error_out;

    modport master (
        output ahb_ready_in, pc_mux_in, misaligned_instr_in, trap_taken_in, mret_in, wfi_in, irq_pending_in,
        input  pc_src_out, pc_out, flush_out, stall_out, misaligned_trap_out, bus_error_out
    );

    modport slave (
        input  ahb_ready_in, pc_mux_in, misaligned_instr_in, trap_taken_in, mret_in, wfi_in, irq_pending_in,
        output pc_src_out, pc_out, flush_out, stall_out, misaligned_trap_out, bus_error_out
    );
endinterface

// File: rtl/msrv32_fetch_timeout.sv
// msrv32_fetch_timeout: 8-bit saturating wait-state counter; expired flags the last allowed wait cycle.
module msrv32_fetch_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en && cnt != 8'hff)
            cnt <= cnt + 8'd1;
    end

    assign expired = cnt == LAST;
endmodule

// File: rtl/msrv32_pc_ctrl.sv
// msrv32_pc_ctrl: PC register and PC-mux select sequencing (boot/trap/mret/wfi, fetch timeout).
// Define MSRV32_PC_CTRL_WFI_EN to enable the WFI sleep state.
module msrv32_pc_ctrl
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    msrv32_pc_ctrl_if.slave   bus
);
    pc_ctrl_state_t state_q, state_d;
    logic [31:0]    pc_q;
    logic           load_pc, expired, cnt_en;
    logic [1:0]     pc_src;
    logic           flush, stall, mis_pulse, berr_pulse;

    always_comb begin
        state_d    = state_q;
        load_pc    = 1'b0;
        pc_src     = PC_SRC_NEXT;
        flush      = 1'b0;
        stall      = !bus.ahb_ready_in;
        mis_pulse  = 1'b0;
        berr_pulse = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_src = PC_SRC_BOOT;
                flush  = 1'b1;
                stall  = 1'b0;
                if (bus.ahb_ready_in) begin
                    load_pc = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mis_pulse  = !bus.trap_taken_in && bus.misaligned_instr_in;
                berr_pulse = !bus.trap_taken_in && !bus.misaligned_instr_in && !bus.ahb_ready_in && expired;
                if (bus.trap_taken_in || mis_pulse || berr_pulse)
                    state_d = ST_TRAP;
                else if (bus.mret_in)
                    state_d = ST_MRET;
`ifdef MSRV32_PC_CTRL_WFI_EN
                else if (bus.wfi_in)
                    state_d = ST_WFI;
`endif
                else
                    load_pc = bus.ahb_ready_in;
            end
            ST_TRAP, ST_MRET: begin
                pc_src = state_q == ST_TRAP ? PC_SRC_TRAP : PC_SRC_EPC;
                flush  = 1'b1;
                if (bus.ahb_ready_in) begin
                    load_pc = 1'b1;
                    state_d = ST_RUN;
                end
            end
`ifdef MSRV32_PC_CTRL_WFI_EN
            ST_WFI: begin
                stall = 1'b1;
                if (bus.irq_pending_in || bus.trap_taken_in)
                    state_d = ST_TRAP;
            end
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_BOOT;
            pc_q    <= BOOT_ADDRESS;
        end else begin
            state_q <= state_d;
            if (load_pc)
                pc_q <= bus.pc_mux_in;
        end
    end

    // Count only while RUN keeps waiting; any advance or state change restarts the window.
    assign cnt_en = state_q == ST_RUN && state_d == ST_RUN && !bus.ahb_ready_in;

    msrv32_fetch_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr      (!cnt_en),
        .en       (cnt_en),
        .expired  (expired)
    );

`ifndef MSRV32_PC_CTRL_WFI_EN
    logic unused_wfi;
    assign unused_wfi = bus.wfi_in ^ bus.irq_pending_in;
`endif

    assign bus.pc_src_out          = pc_src;
    assign bus.pc_out              = pc_q;
    assign bus.flush_out           = flush;
    assign bus.stall_out           = stall;
    assign bus.misaligned_trap_out = mis_pulse;
    assign bus.bus_error_out       = berr_pulse;
endmodule

// File: tb/tb_msrv32_pc_ctrl.sv
// tb_msrv32_pc_ctrl: directed and random stimulus checked against a cycle-level behavioural model.
module tb_msrv32_pc_ctrl;
    localparam logic [31:0] BOOT    = 32'h0000_0000;
    localparam int          TIMEOUT = 16;
    localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2, M_MRET = 3, M_WFI = 4;
`ifdef MSRV32_PC_CTRL_WFI_EN
    localparam bit WFI_EN = 1'b1;
`else
    localparam bit WFI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int          m_mode, n_mode, m_low, n_low;
    logic [31:0] m_pc, n_pc;
    logic [37:0] exp_v;

    msrv32_pc_ctrl_if bus();

    msrv32_pc_ctrl #(.BOOT_ADDRESS(BOOT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] obs();
        return {bus.pc_src_out, bus.flush_out, bus.stall_out, bus.misaligned_trap_out, bus.bus_error_out, bus.pc_out};
    endfunction

    // Expected outputs this cycle and the architectural effect of the coming edge.
    task automatic model();
        logic [1:0] src;
        logic fl, st, mis, be;
        logic r;
        r = bus.ahb_ready_in;
        src = 2'b11; fl = 1'b0; st = !r; mis = 1'b0; be = 1'b0;
        n_mode = m_mode; n_pc = m_pc; n_low = 0;
        if (m_mode == M_BOOT) begin
            src = 2'b00; fl = 1'b1; st = 1'b0;
            if (r) begin n_pc = bus.pc_mux_in; n_mode = M_RUN; end
        end else if (m_mode == M_RUN) begin
            if (bus.trap_taken_in) n_mode = M_TRAP;
            else if (bus.misaligned_instr_in) begin mis = 1'b1; n_mode = M_TRAP; end
            else if (!r && m_low + 1 == TIMEOUT) begin be = 1'b1; n_mode = M_TRAP; end
            else if (bus.mret_in) n_mode = M_MRET;
            else if (bus.wfi_in && WFI_EN) n_mode = M_WFI;
            else if (r) n_pc = bus.pc_mux_in;
            else n_low = m_low + 1;
        end else if (m_mode == M_TRAP || m_mode == M_MRET) begin
            src = m_mode == M_TRAP ? 2'b10 : 2'b01; fl = 1'b1;
            if (r) begin n_pc = bus.pc_mux_in; n_mode = M_RUN; end
        end else begin
            st = 1'b1;
            if (bus.irq_pending_in || bus.trap_taken_in) n_mode = M_TRAP;
        end
        exp_v = {src, fl, st, mis, be, m_pc};
    endtask

    task automatic drive(input logic r, input logic [31:0] mux, input logic mis, input logic tr,
                         input logic mr, input logic wf, input logic irq);
        bus.ahb_ready_in = r; bus.pc_mux_in = mux; bus.misaligned_instr_in = mis;
        bus.trap_taken_in = tr; bus.mret_in = mr; bus.wfi_in = wf; bus.irq_pending_in = irq;
        @(negedge clk);
        model();
    endtask

    task automatic tick();
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_low = n_low;
        #1;
    endtask

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = BOOT; m_low = 0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'hdead_beef, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs() !== {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, BOOT}) begin
            errors++; $display("FAIL reset got=%h exp=%h", obs(), {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, BOOT});
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_boot_run();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL boot_run[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            drive(i >= 3, m_pc + 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL stall[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] mux [4] = '{32'h100, 32'h104, 32'h80, 32'h84};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mux[i], i == 1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL misaligned[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_trap_mret();
        for (int i = 0; i < 4; i++) begin
            drive(i != 1, 32'h200 + 32'(4 * i), 1'b0, i == 0, i == 0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL trap_mret[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h280 + 32'(4 * i), 1'b0, 1'b0, i == 0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL mret[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            drive(i >= TIMEOUT, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_wfi();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, m_pc + 4, 1'b0, 1'b0, 1'b0, i == 0, i == 6);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL wfi[%0d] got=%h exp=%h", i, obs(), exp_v); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom_range(0, 16'hffff), 2'b00} + 32'h1000,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0);
            checks++;
            if (obs() !== exp_v) begin errors++; $display("FAIL random[%0d] got=%h exp=%h", i, obs(), exp_v); end
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                model();
                #1;
                checks++;
                if (obs() !== exp_v) begin errors++; $display("FAIL mid_reset[%0d] got=%h exp=%h", i, obs(), exp_v); end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_boot_run();
        test_stall();
        test_misaligned();
        test_trap_mret();
        test_timeout();
        test_wfi();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/msrv32_pc_ctrl.md
# msrv32_pc_ctrl

Program-counter sequencing controller for the msrv32 RV32I core. Owns the architectural PC register and drives the 2-bit PC-source select into the PC mux datapath (boot / epc / trap / next), so the datapath stays purely combinational. Handles instruction-bus wait states with a bounded timeout, misaligned-target and trap redirects, MRET return, and optional WFI. Sits between the CSR/trap unit, the decoder and the PC mux in the fetch stage.

## Interface
- BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset and in BOOT
- TIMEOUT_CYCLES, 16, consecutive ahb_ready_in-low cycles in RUN before bus error (min 2, max 255)
- clk_in  input  1  core clock, rising edge
- rst_n_in  input  1  reset; asynchronous, active-low
- ahb_ready_in  input  1  instruction-bus ready; PC advances only when high
- pc_mux_in  input  32  next-PC value from the PC mux
- misaligned_instr_in  input  1  taken branch/jump target not word aligned
- trap_taken_in  input  1  CSR unit requests trap entry (interrupt/exception)
- mret_in  input  1  decoded MRET in execute
- wfi_in  input  1  decoded WFI in execute (used only with WFI feature)
- irq_pending_in  input  1  enabled interrupt pending (WFI wake-up)
- pc_src_out  output  2  mux select: 00 boot, 01 epc, 10 trap, 11 next
- pc_out  output  32  architectural PC register
- flush_out  output  1  kill instruction in fetch/decode
- stall_out  output  1  hold pipeline this cycle
- misaligned_trap_out  output  1  one-cycle pulse: misaligned exception to CSR
- bus_error_out  output  1  one-cycle pulse: fetch timeout exception to CSR

## Operation
- States: BOOT, RUN, TRAP, MRET, WFI. Reset -> BOOT.
- Reset values: pc_out=BOOT_ADDRESS, pc_src_out=00, flush_out=1, stall_out=0, both pulse outputs 0, timeout counter 0.
- BOOT: pc_src_out=00, flush_out=1; if ahb_ready_in, pc_out<=pc_mux_in, -> RUN; else stay.
- RUN: pc_src_out=11. Event priority, evaluated each cycle: trap_taken_in > misaligned_instr_in > bus timeout > mret_in > wfi_in > normal.
  - trap_taken_in: pc held, -> TRAP.
  - misaligned_instr_in: pc held, misaligned_trap_out=1, -> TRAP.
  - timeout (counter reaches TIMEOUT_CYCLES-1 with ahb_ready_in low): bus_error_out=1, counter cleared, -> TRAP.
  - mret_in: pc held, -> MRET.
  - wfi_in: pc held, -> WFI.
  - normal: ahb_ready_in high -> pc_out<=pc_mux_in, counter cleared; low -> stall_out=1, counter+1 (saturating 8-bit).
- TRAP: pc_src_out=10, flush_out=1; load pc_mux_in when ahb_ready_in, -> RUN; else stay with stall_out=1.
- MRET: same as TRAP with pc_src_out=01.
- WFI: pc_src_out=11, stall_out=1, flush_out=0, pc held; irq_pending_in or trap_taken_in -> TRAP.
- stall_out is 0 in every state whenever ahb_ready_in is high, except WFI.
- Timeout counter counts only in RUN; cleared on any state change.

## Timing
- pc_src_out, flush_out, stall_out are decoded from registered state plus ahb_ready_in (Mealy only on stall); pulses are combinational from RUN inputs, valid same cycle.
- Redirect latency: event at edge N sampled in RUN -> TRAP/MRET during cycle N+1 -> pc_out = target after edge N+1 (if ahb_ready_in high).
- Normal advance: zero bubbles; pc_out updates every ready cycle.
- Simultaneous mret_in and trap_taken_in: trap wins; MRET is dropped (CSR re-executes).
- Reset asserted mid-state: immediate return to reset values, any pending pulse suppressed.

## Configuration
- MSRV32_PC_CTRL_WFI_EN defined: WFI state present as above.
- Undefined: no WFI state; wfi_in ignored and treated as normal instruction (PC advances, no stall).

## Structure
- Shared package msrv32_pkg: PC_SRC_BOOT/EPC/TRAP/NEXT 2-bit constants, pc_ctrl state enum.
- One sub-module: msrv32_fetch_timeout (8-bit saturating counter, clear/enable inputs, expired output).

## Test plan
- Reset release, ahb_ready_in=1, pc_mux_in=0 -> BOOT one cycle, pc_src_out=00, flush_out=1; then RUN, pc_src_out=11, pc_out follows 0,4,8.
- RUN, ahb_ready_in low 3 cycles -> stall_out=1 for 3 cycles, pc_out constant; resume advances with no bubble.
- misaligned_instr_in pulse at PC=0x100 -> misaligned_trap_out=1 same cycle, next cycle pc_src_out=10, pc_out=pc_mux_in (0x80) after.
- trap_taken_in and mret_in same cycle -> TRAP entered, pc_src_out=10, never 01.
- ahb_ready_in held low 16 cycles (TIMEOUT_CYCLES=16) -> bus_error_out pulses on 16th cycle, then TRAP.
- With MSRV32_PC_CTRL_WFI_EN: wfi_in then irq_pending_in after 5 cycles -> stall_out=1 for 5 cycles, then TRAP; without macro, pc advances by 4.
